// File: rtl/uart_transmitter.sv
// uart_transmitter: serializes one DATA_WIDTH-bit word per request into a UART frame
// Frame: start(0), data LSB first, optional parity, stop(1); each bit lasts eff_prescale clocks.
// Ports: clk, reset (sync, active-high), parity_type (0 even / 1 odd), parity_enable,
//   prescale[5:0] (clocks per bit), data_valid, parallel_data[DATA_WIDTH-1:0],
//   serial_data_out (registered line, idles high), busy.
// Define UART_TX_TWO_STOP_BITS_EN for two stop bits; one stop bit otherwise.
module uart_transmitter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  parity_type,
  input  logic                  parity_enable,
  input  logic [5:0]            prescale,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  serial_data_out,
  output logic                  busy
);
  localparam int IW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic ptype_q, ptype_d, pen_q, pen_d, line_q, line_d, busy_q, busy_d, tc;
`ifdef UART_TX_TWO_STOP_BITS_EN
  logic stop2_q, stop2_d;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      ptype_q <= 1'b0;
      pen_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_TWO_STOP_BITS_EN
      stop2_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ptype_q <= ptype_d;
      pen_q   <= pen_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
`ifdef UART_TX_TWO_STOP_BITS_EN
      stop2_q <= stop2_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    data_d  = data_q;
    ptype_d = ptype_q;
    pen_d   = pen_q;
`ifdef UART_TX_TWO_STOP_BITS_EN
    stop2_d = stop2_q;
`endif
    tc = cnt_q == pre_q - 6'd1;
    if (state_q == IDLE) begin
      if (data_valid) begin
        state_d = START;
        cnt_d   = '0;
        data_d  = parallel_data;
        ptype_d = parity_type;
        pen_d   = parity_enable;
        pre_d   = (prescale < 6'd2) ? 6'd1 : prescale;
      end
    end else begin
      cnt_d = tc ? 6'd0 : cnt_q + 6'd1;
      if (tc)
        case (state_q)
          START: begin
            state_d = DATA;
            idx_d   = '0;
          end
          DATA:
            if (idx_q == IW'(DATA_WIDTH - 1)) state_d = pen_q ? PARITY : STOP;
            else idx_d = idx_q + IW'(1);
          PARITY: state_d = STOP;
`ifdef UART_TX_TWO_STOP_BITS_EN
          // stop2 toggles once per stop bit, so it is back at 0 when the frame ends
          default: begin
            stop2_d = ~stop2_q;
            if (stop2_q) state_d = IDLE;
          end
`else
          default: state_d = IDLE;
`endif
        endcase
    end
  end
  // line value follows the next state so it is registered alongside it
  always_comb begin
    line_d = (state_d == START)  ? 1'b0 :
             (state_d == DATA)   ? data_d[idx_d] :
             (state_d == PARITY) ? (^data_d) ^ ptype_d : 1'b1;
    busy_d = state_d != IDLE;
  end
  assign serial_data_out = line_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of uart_transmitter line timing and busy
module tb_uart_transmitter;
  logic clk = 1'b0;
  logic reset, parity_type, parity_enable, data_valid, serial_data_out, busy;
  logic [5:0] prescale;
  logic [7:0] parallel_data;
  int n = 0;
  int err = 0;
  uart_transmitter #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .parity_type(parity_type), .parity_enable(parity_enable),
    .prescale(prescale), .data_valid(data_valid), .parallel_data(parallel_data),
    .serial_data_out(serial_data_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    n++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_line"}, serial_data_out, 1'b1);
  endtask
  task automatic go(input logic [7:0] d, input logic pen, input logic pt, input logic [5:0] ps);
    @(negedge clk);
    parallel_data = d;
    parity_enable = pen;
    parity_type = pt;
    prescale = ps;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask
  task automatic frame(input string tag, input logic [7:0] d, input logic pen, input logic pt, input int pre);
    logic [11:0] bits;
    int nb;
    bits = pen ? {2'b11, (^d) ^ pt, d, 1'b0} : {3'b111, d, 1'b0};
    nb = 10 + int'(pen);
`ifdef UART_TX_TWO_STOP_BITS_EN
    nb++;
`endif
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < pre; c++) begin
        @(negedge clk);
        chk($sformatf("%s_bit%0d_line", tag, b), serial_data_out, bits[b]);
        chk($sformatf("%s_bit%0d_busy", tag, b), busy, 1'b1);
      end
  endtask
  initial begin
    reset = 1'b1;
    data_valid = 1'b1;
    parity_type = 1'b0;
    parity_enable = 1'b0;
    prescale = 6'd8;
    parallel_data = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_line", serial_data_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    reset = 1'b0;
    data_valid = 1'b0;
    idle("post_rst");
    idle("post_rst2");
    go(8'hA5, 1'b0, 1'b0, 6'd8);
    frame("a5_p8", 8'hA5, 1'b0, 1'b0, 8);
    idle("a5_p8");
    go(8'hA5, 1'b1, 1'b0, 6'd4);
    frame("a5_even", 8'hA5, 1'b1, 1'b0, 4);
    idle("a5_even");
    go(8'hA5, 1'b1, 1'b1, 6'd4);
    frame("a5_odd", 8'hA5, 1'b1, 1'b1, 4);
    idle("a5_odd");
    @(negedge clk);
    parallel_data = 8'h00;
    parity_enable = 1'b0;
    prescale = 6'd2;
    data_valid = 1'b1;
    @(posedge clk);
    frame("b2b_00", 8'h00, 1'b0, 1'b0, 2);
    @(negedge clk);
    chk("b2b_gap_busy", busy, 1'b0);
    chk("b2b_gap_line", serial_data_out, 1'b1);
    parallel_data = 8'hFF;
    @(posedge clk);
    #1 data_valid = 1'b0;
    frame("b2b_ff", 8'hFF, 1'b0, 1'b0, 2);
    idle("b2b_ff");
    go(8'hA5, 1'b0, 1'b0, 6'd4);
    parallel_data = 8'h3C;
    prescale = 6'd16;
    parity_enable = 1'b1;
    parity_type = 1'b1;
    data_valid = 1'b1;
    frame("midchg", 8'hA5, 1'b0, 1'b0, 4);
    data_valid = 1'b0;
    idle("midchg");
    idle("midchg_drop");
    go(8'hA5, 1'b0, 1'b0, 6'd0);
    frame("pre0", 8'hA5, 1'b0, 1'b0, 1);
    idle("pre0");
    go(8'h5A, 1'b0, 1'b0, 6'd1);
    frame("pre1", 8'h5A, 1'b0, 1'b0, 1);
    idle("pre1");
    for (int i = 0; i < 64; i++) begin
      logic [7:0] d;
      logic pen, pt;
      logic [5:0] ps;
      d = 8'($urandom);
      pen = 1'($urandom);
      pt = 1'($urandom);
      ps = 6'($urandom_range(0, 5));
      go(d, pen, pt, ps);
      frame($sformatf("rnd%0d", i), d, pen, pt, (ps < 6'd2) ? 1 : int'(ps));
      idle($sformatf("rnd%0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
